// File: rtl/csa_pkg.sv
// Shared definitions for the carry-select adder.
//   CSA_WIDTH / CSA_BLOCK : default operand width and slice width
//   num_blocks()          : number of carry-select slices for a given width/slice size
//   csa_result_t          : packed {cout, sum} result at the default width
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 4;
  localparam int unsigned CSA_BLOCK = 2;

  function automatic int unsigned num_blocks(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

  typedef struct packed {
    logic                 cout;
    logic [CSA_WIDTH-1:0] sum;
  } csa_result_t;

endpackage

// File: rtl/csa_rca_block.sv
// BLOCK-bit ripple-carry adder slice.
//   a, b : slice operands
//   ci   : carry in
//   s    : slice sum
//   co   : carry out
module csa_rca_block
  import csa_pkg::*;
#(
  parameter int unsigned BLOCK = CSA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[BLOCK];
  end

endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder with a registered result: {cout, sum} = a + b + cin, one cycle latency.
// Slice 0 ripples from cin; each higher slice precomputes both carry-in cases and selects on
// the real carry from the slice below.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : operands valid this cycle
//   a, b, cin  : unsigned operands and carry in
//   out_valid  : registered result strobe
//   sum, cout  : registered result (held while in_valid is low)
//   ovf        : registered signed overflow, present only when CSA_OVF_EN is defined
module carry_select_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned BLOCK = CSA_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned BlockSafe = (BLOCK == 0) ? 1 : BLOCK;
  localparam int unsigned NumBlocks = num_blocks(WIDTH, BlockSafe);

  if (WIDTH < 2 || BLOCK == 0 || (WIDTH % BlockSafe) != 0) begin : g_param_check
    $error("carry_select_adder: WIDTH must be >= 2 and a multiple of BLOCK");
  end

  // Unpacked so each slice carry is a distinct net in the select chain.
  logic             carry [NumBlocks+1];
  logic [WIDTH-1:0] sum_d;

  assign carry[0] = cin;

  for (genvar k = 0; k < NumBlocks; k++) begin : g_slice
    if (k == 0) begin : g_ripple
      logic co;
      csa_rca_block #(
        .BLOCK(BLOCK)
      ) u_rca (
        .a (a[BLOCK-1:0]),
        .b (b[BLOCK-1:0]),
        .ci(carry[0]),
        .s (sum_d[BLOCK-1:0]),
        .co(co)
      );
      assign carry[1] = co;
    end else begin : g_select
      logic [BLOCK-1:0] s0;
      logic [BLOCK-1:0] s1;
      logic             co0;
      logic             co1;

      csa_rca_block #(
        .BLOCK(BLOCK)
      ) u_rca0 (
        .a (a[k*BLOCK +: BLOCK]),
        .b (b[k*BLOCK +: BLOCK]),
        .ci(1'b0),
        .s (s0),
        .co(co0)
      );

      csa_rca_block #(
        .BLOCK(BLOCK)
      ) u_rca1 (
        .a (a[k*BLOCK +: BLOCK]),
        .b (b[k*BLOCK +: BLOCK]),
        .ci(1'b1),
        .s (s1),
        .co(co1)
      );

      assign sum_d[k*BLOCK +: BLOCK] = carry[k] ? s1 : s0;
      assign carry[k+1]              = carry[k] ? co1 : co0;
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[NumBlocks];
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef CSA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Same-sign operands producing an opposite-sign result overflow the signed range.
  assign ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_adder.sv
module tb_carry_select_adder;
  import csa_pkg::*;

  logic       clk;
  logic       rst_n;

  // Default 4-bit / 2-slice instance
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout;

  // 8-bit / 4-slice instance
  logic       in_valid8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       out_valid8;
  logic [7:0] sum8;
  logic       cout8;

`ifdef CSA_OVF_EN
  logic       ovf;
  logic       ovf8;
`endif

  int checks = 0;
  int errors = 0;

  carry_select_adder #(
    .WIDTH(4),
    .BLOCK(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
    .cout     (cout)
`ifdef CSA_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  carry_select_adder #(
    .WIDTH(8),
    .BLOCK(4)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .out_valid(out_valid8),
    .sum      (sum8),
    .cout     (cout8)
`ifdef CSA_OVF_EN
    ,
    .ovf      (ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: full (w+1)-bit unsigned sum.
  function automatic int unsigned add_ref(input int unsigned x, input int unsigned y,
                                          input int unsigned c);
    return x + y + c;
  endfunction

  // Signed overflow: does the two's-complement sum leave the w-bit signed range?
  function automatic logic ovf_ref(input int unsigned x, input int unsigned y,
                                   input int unsigned c, input int unsigned w);
    int sx;
    int sy;
    int s;
    int lim;
    lim = 1 << (w - 1);
    sx  = int'(x);
    sy  = int'(y);
    if (sx >= lim) sx = sx - 2 * lim;
    if (sy >= lim) sy = sy - 2 * lim;
    s = sx + sy + int'(c);
    return (s >= lim) || (s < -lim);
  endfunction

  // Behavioural model of the registered outputs.
  csa_result_t m_res;
  logic        m_valid;
  logic        m_ovf;
  logic [8:0]  m8_res;
  logic        m8_valid;
  logic        m8_ovf;
  int unsigned t4;
  int unsigned t8;

  assign t4 = add_ref(32'(a), 32'(b), 32'(cin));
  assign t8 = add_ref(32'(a8), 32'(b8), 32'(cin8));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res    <= '0;
      m_valid  <= 1'b0;
      m_ovf    <= 1'b0;
      m8_res   <= '0;
      m8_valid <= 1'b0;
      m8_ovf   <= 1'b0;
    end else begin
      m_valid  <= in_valid;
      m8_valid <= in_valid8;
      if (in_valid) begin
        m_res <= t4[4:0];
        m_ovf <= ovf_ref(32'(a), 32'(b), 32'(cin), 4);
      end
      if (in_valid8) begin
        m8_res <= t8[8:0];
        m8_ovf <= ovf_ref(32'(a8), 32'(b8), 32'(cin8), 8);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("valid4", 32'(out_valid), 32'(m_valid));
    check("sum4", 32'(sum), 32'(m_res.sum));
    check("cout4", 32'(cout), 32'(m_res.cout));
    check("valid8", 32'(out_valid8), 32'(m8_valid));
    check("sum8", 32'(sum8), 32'(m8_res[7:0]));
    check("cout8", 32'(cout8), 32'(m8_res[8]));
`ifdef CSA_OVF_EN
    check("ovf4", 32'(ovf), 32'(m_ovf));
    check("ovf8", 32'(ovf8), 32'(m8_ovf));
`endif
  end

  // Drive one 4-bit vector and check the registered result one cycle later.
  task automatic apply4(input string name, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [3:0] esum, input logic ecout);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_sum"}, 32'(sum), 32'(esum));
    check({name, "_cout"}, 32'(cout), 32'(ecout));
    check({name, "_valid"}, 32'(out_valid), 32'(1'b1));
    check({name, "_model"}, 32'(m_res), 32'({ecout, esum}));
  endtask

  task automatic apply8(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] esum, input logic ecout);
    a8        = va;
    b8        = vb;
    cin8      = vc;
    in_valid8 = 1'b1;
    @(negedge clk);
    check({name, "_sum"}, 32'(sum8), 32'(esum));
    check({name, "_cout"}, 32'(cout8), 32'(ecout));
    check({name, "_model"}, 32'(m8_res), 32'({ecout, esum}));
    in_valid8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    a         = 4'd5;
    b         = 4'd6;
    cin       = 1'b0;
    in_valid8 = 1'b0;
    a8        = '0;
    b8        = '0;
    cin8      = 1'b0;
    #2 rst_n  = 1'b0;

    // Reset held across clock edges with valid operands present
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    rst_n = 1'b1;

    // Basic and carry-select paths
    apply4("v0", 4'd0, 4'd0, 1'b0, 4'b0000, 1'b0);
    apply4("v1", 4'd1, 4'd1, 1'b0, 4'b0010, 1'b0);
    apply4("v2", 4'd2, 4'd3, 1'b1, 4'b0110, 1'b0);
    apply4("v3", 4'd5, 4'd6, 1'b0, 4'b1011, 1'b0);
    apply4("v4", 4'd15, 4'd1, 1'b1, 4'b0001, 1'b1);
    apply4("v5", 4'd12, 4'd12, 1'b1, 4'b1001, 1'b1);
    apply4("v6", 4'd9, 4'd6, 1'b0, 4'b1111, 1'b0);
    apply4("v7", 4'd15, 4'd15, 1'b1, 4'b1111, 1'b1);

    // Valid pattern 1,0,1 with hold during the idle cycle
    apply4("p1", 4'd3, 4'd4, 1'b0, 4'b0111, 1'b0);
    in_valid = 1'b0;
    a        = 4'b1010;
    b        = 4'b0101;
    cin      = 1'b1;
    @(negedge clk);
    check("p0_valid", 32'(out_valid), 32'(0));
    check("p0_hold", 32'(sum), 32'(4'b0111));
    apply4("p2", 4'd1, 4'd2, 1'b0, 4'b0011, 1'b0);

`ifdef CSA_OVF_EN
    apply4("o1", 4'd7, 4'd1, 1'b0, 4'b1000, 1'b0);
    check("o1_ovf", 32'(ovf), 32'(1));
    apply4("o2", 4'd8, 4'd8, 1'b0, 4'b0000, 1'b1);
    check("o2_ovf", 32'(ovf), 32'(1));
    apply4("o3", 4'd3, 4'd2, 1'b0, 4'b0101, 1'b0);
    check("o3_ovf", 32'(ovf), 32'(0));
`endif

    // Exhaustive back-to-back sweep; the compare process checks every cycle
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          a        = 4'(i);
          b        = 4'(j);
          cin      = 1'(c);
          in_valid = 1'b1;
          @(negedge clk);
        end
      end
    end
    check("sweep_last", 32'({cout, sum}), 32'(5'd31));
    in_valid = 1'b0;
    @(negedge clk);

    // Reset asserted mid-stream drops out_valid without a clock edge
    apply4("m1", 4'd7, 4'd7, 1'b0, 4'b1110, 1'b0);
    a = 4'd1;
    b = 4'd1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_sum", 32'(sum), 32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'(0));

    // 8-bit / 4-slice instance: extremes then random traffic
    apply8("w0", 8'hff, 8'hff, 1'b1, 8'hff, 1'b1);
    apply8("w1", 8'h0f, 8'h01, 1'b0, 8'h10, 1'b0);
    apply8("w2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    for (int n = 0; n < 200; n++) begin
      in_valid8 = ($urandom_range(0, 3) != 0);
      a8        = 8'($urandom);
      b8        = 8'($urandom);
      cin8      = 1'($urandom);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Parameterised carry-select adder computing A + B + cin, with a registered result and a valid strobe.
- Operand split into BLOCK-bit slices. Slice 0 is a plain ripple adder. Every higher slice precomputes sum/carry for carry-in 0 and 1, then muxes on the real carry from the slice below.
- Sits in datapaths as a single-cycle-latency pipelined adder. Default configuration is the 4-bit, 2-slice adder.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be ≥ 2.
- BLOCK, 2, slice width in bits; WIDTH % BLOCK == 0 is required and is checked by an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry in
- out_valid  output  1  registered; sum/cout valid
- sum  output  WIDTH  registered sum, low WIDTH bits of a+b+cin
- cout  output  1  registered carry out (bit WIDTH of a+b+cin)

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - sum = 0, cout = 0, out_valid = 0.
  - Release is synchronous to the next clk edge.
- Datapath is combinational. {cout, sum} = a + b + cin, computed as WIDTH+1-bit unsigned; no truncation other than the split into sum and cout.
- Carry-select structure:
  - N = WIDTH/BLOCK slices.
  - Slice 0 is a ripple adder driven by cin.
  - Slice k>0 has two ripple adders, with fixed carry-in 0 and 1. The carry out of slice k-1 selects both sum bits and the carry of slice k.
  - The final slice's selected carry is cout.
- Latency is 1 cycle:
  - Every rising clk where in_valid=1: sum/cout capture the result and out_valid=1 in the following cycle.
  - Where in_valid=0: out_valid=0 next cycle, and sum/cout hold their last value (not cleared).
- Back-to-back: a new operand every cycle gives a result every cycle. No backpressure.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, cout = 1.
  - Zero + zero + 0 gives sum = 0, cout = 0.
  - Wrap-around is reported only via cout.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid drops immediately.
- X/undefined operands with in_valid=0 must not affect out_valid.

Optional Feature:
- Macro CSA_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit, registered, reset 0), placed after cout.
  - ovf = signed two's-complement overflow of a+b+cin: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - ovf updates under the same in_valid rule as sum.
- When undefined: port absent, no logic generated.

Decomposition:
- Shared package csa_pkg:
  - default WIDTH/BLOCK localparams;
  - function num_blocks(width, block);
  - packed typedef for the {cout, sum} result.
- Sub-module csa_rca_block: BLOCK-bit ripple-carry adder with ports a, b, ci, s, co; instantiated once for slice 0 and twice per higher slice.
- Top module: generate loop, carry-select muxes, output register.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=5, b=6 -> sum=0, cout=0, out_valid=0. After release, first valid gives a result 1 cycle later.
- Basic (WIDTH=4):
  - a=0,b=0,cin=0 -> sum=0000, cout=0.
  - a=1,b=1,cin=0 -> sum=0010, cout=0.
  - a=2,b=3,cin=1 -> sum=0110, cout=0.
  - a=5,b=6,cin=0 -> sum=1011, cout=0.
- Carry out/select path:
  - a=15,b=1,cin=1 -> sum=0001, cout=1.
  - a=12,b=12,cin=1 -> sum=1001, cout=1.
  - a=9,b=6,cin=0 -> sum=1111, cout=0.
- Extremes: a=15,b=15,cin=1 -> sum=1111, cout=1. Exhaustive 512-vector sweep vs a+b+cin matches every cycle with 1-cycle latency.
- Valid/hold: in_valid pulse pattern 1,0,1 -> out_valid 1,0,1 one cycle later. sum holds during the 0 cycle. Assert rst_n mid-stream -> out_valid=0 immediately.
- CSA_OVF_EN:
  - a=7,b=1,cin=0 -> ovf=1.
  - a=8,b=8,cin=0 -> ovf=1, sum=0000, cout=1.
  - a=3,b=2,cin=0 -> ovf=0.
- Non-default parameters: WIDTH=8, BLOCK=4 with random vectors vs reference sum.
